ifu_prefetch: RTL

- Instruction prefetch queue between the instruction bus and the IF stage.
- Owns the fetch PC, issues sequential Avalon reads while buffer space exists, and honours waitrequest.
- Buffers {pc, instruction} pairs in a small FIFO; IF consumes them with a valid/ready handshake.
- On redirect (branch/flush), discards queued and in-flight fetches and restarts at the new PC.

---
 rtl/ifu_prefetch_pkg.sv | 33 +++
 rtl/ifu_prefetch_if.sv | 30 +++
 rtl/ifu_fifo.sv | 46 ++++
 rtl/ifu_prefetch.sv | 88 ++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared types for the instruction prefetch slice: Avalon request/response
// structs, the buffered {pc, instruction} entry and an address-alignment helper.
package ifu_prefetch_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    pc_t        address;
    logic [3:0] byte_enable;
    logic       read;
    logic       write;
    data_t      writedata;
  } avalon_req_t;

  typedef struct packed {
    data_t readdata;
    logic  waitrequest;
  } avalon_resp_t;

  typedef struct packed {
    pc_t   pc;
    data_t instruction;
  } if_fetch_entry_t;

  function automatic pc_t word_align(pc_t a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Bundles the instruction-bus port and the IF-stage fetch handshake.
// master = prefetch unit, slave = memory/IF side.
interface ifu_prefetch_if;

  ifu_prefetch_pkg::avalon_req_t  ibus_avalon_req;
  ifu_prefetch_pkg::avalon_resp_t ibus_avalon_resp;
  logic                           fetch_valid;
  logic                           fetch_ready;
  ifu_prefetch_pkg::pc_t          fetch_pc;
  ifu_prefetch_pkg::data_t        fetch_instruction;

  modport master (
    output ibus_avalon_req,
    input  ibus_avalon_resp,
    output fetch_valid,
    input  fetch_ready,
    output fetch_pc,
    output fetch_instruction
  );

  modport slave (
    input  ibus_avalon_req,
    output ibus_avalon_resp,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_pc,
    input  fetch_instruction
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear; clear wins over push.
// Storage is not reset; only pointers and occupancy are.
module ifu_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  if_fetch_entry_t            din,
  output if_fetch_entry_t            dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  if_fetch_entry_t mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited
// sequential Avalon reads and buffers {pc, instruction} pairs for IF.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter pc_t RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  pc_t                   redirect_pc,
  ifu_prefetch_if.master        bus
);

  localparam int AW = $clog2(DEPTH);

  pc_t             pc_q;
  pc_t             address;
  logic            read;
  logic            accept;
  logic            push;
  logic            pop;
  logic [AW+1:0]   inflight;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  if_fetch_entry_t entry;
  if_fetch_entry_t head;

  // stage p1: the single read accepted last cycle, whose data arrives now
  logic            pend_vld_p1;
  pc_t             pend_pc_p1;

  assign address  = word_align(pc_q);
  assign inflight = {1'b0, count} + {{(AW+1){1'b0}}, pend_vld_p1};
  assign read     = !rst && !redirect && (inflight < (AW+2)'(DEPTH));
  assign accept   = read && !bus.ibus_avalon_resp.waitrequest;

  // A response coinciding with a redirect belongs to the old stream.
  assign push     = pend_vld_p1 && !redirect;
  assign pop      = !empty && bus.fetch_ready && !redirect && !rst;
  assign entry    = '{pc: pend_pc_p1, instruction: bus.ibus_avalon_resp.readdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pend_vld_p1 <= 1'b0;
    end else begin
      pend_vld_p1 <= accept;
      if (redirect)    pc_q <= redirect_pc;
      else if (accept) pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_pc_p1 <= address;
  end

  // stage p2: FIFO storage, head drives the IF handshake with no bypass
  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    bus.ibus_avalon_req             = '0;
    bus.ibus_avalon_req.address     = address;
    bus.ibus_avalon_req.byte_enable = 4'b1111;
    bus.ibus_avalon_req.read        = read;
    bus.fetch_valid                 = !empty;
    bus.fetch_pc                    = head.pc;
    bus.fetch_instruction           = head.instruction;
  end

  push_on_full_chk : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop))
    else $error("ifu_prefetch: push into full FIFO");

endmodule
